muldiv_unit: RTL
================

# muldiv_unit

Iterative unsigned 32-bit multiply/divide execute unit that sits directly upstream of the general-purpose register file and drives its write port (`write_enable`, `addrC`, `data_in_C`). Operands arrive from the register-file read ports (`data_out_A`/`data_out_B`) with a start pulse. The unit iterates for a fixed 32 cycles, then issues a single-cycle write-back of the selected result word to the destination register.

## Interface
- `WIDTH`, 32: operand/result width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock, shared with the register file.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only on edges where `busy`=0.
- `op`  in  2  operation: 00 MULLO (low word of a*b), 01 MULHI (high word of a*b), 10 DIVQ (a/b), 11 DIVR (a%b).
- `dest`  in  5  destination register index.
- `operand_a`  in  WIDTH  dividend / multiplicand (from `data_out_A`).
- `operand_b`  in  WIDTH  divisor / multiplier (from `data_out_B`).
- `busy`  out  1  high from acceptance through the write-back cycle.
- `write_enable`  out  1  register-file write strobe, one cycle.
- `addrC`  out  5  register-file write address.
- `data_in_C`  out  WIDTH  register-file write data.

## Operation
- States: IDLE, RUN, WB.
- **IDLE**
  - `busy`=0.
  - On an edge with `start`=1, capture `op`, `dest`, `operand_a` and `operand_b`, clear the 5-bit iteration counter, and go to RUN.
- **RUN**
  - One iteration per edge. After the 32nd iteration (counter = 31 at the edge), go to WB.
- **Multiply**
  - Unsigned shift-add into a 64-bit product register, LSB of the multiplier first.
  - MULLO returns product[31:0]; MULHI returns product[63:32].
- **Divide**
  - Unsigned restoring division with a 33-bit partial remainder, MSB of the dividend first.
  - DIVQ returns the quotient; DIVR returns the remainder.
- **Divide by zero**
  - No trap; the full 32-cycle latency is kept.
  - DIVQ = 32'hFFFFFFFF; DIVR = `operand_a` as captured.
- **Entering WB**
  - `addrC` <= captured `dest` and `data_in_C` <= result (both registered).
  - `write_enable` = 1 for exactly the WB cycle, unless `dest`=0, in which case `write_enable` stays 0 but WB is still traversed.
  - WB -> IDLE unconditionally after one cycle.
- **Output hold**: `addrC` and `data_in_C` hold their last values until the next WB. `write_enable` is 0 in every state except WB.
- **Ignored starts**: `start` while `busy`=1 (RUN or WB) is ignored and is not queued.
- **Operand stability**: operand and `op` changes after acceptance have no effect.
- **Reset**
  - Asynchronous; takes effect immediately in any state, including mid-RUN or mid-WB.
  - Clears state to IDLE and sets `busy`, `write_enable`, `addrC`, `data_in_C`, the counter and all datapath registers to 0.
  - An in-flight operation is discarded with no write-back.

## Timing
- Start sampled at edge E0: `busy`=1 after E0.
- Iterations occur at E1..E32. WB state is entered at E32.
- `write_enable`=1 between E32 and E33; the register file captures at E33.
- At E33 the unit returns to IDLE and `busy` falls.
- Latency from start edge to register-file write edge: 33 cycles. Throughput: one operation per 34 cycles; the earliest next accepted start is E34.
- Outputs are registered; there is no combinational path from the inputs to the outputs.
- After `rst` deasserts, the first edge may accept `start`.

## Test plan
- MULLO 7*6 to `dest`=5, start at E0 -> `write_enable`=1 for exactly one cycle after E32, `addrC`=5, `data_in_C`=42; `busy` low after E33.
- MULHI and MULLO of 32'hFFFFFFFF*32'hFFFFFFFF -> 32'hFFFFFFFE and 32'h00000001 respectively.
- DIVQ/DIVR 100 by 7 -> 14 and 2; 32'h80000000 by 3 -> 32'h2AAAAAAA and 2.
- Divide by zero with a=123 -> DIVQ 32'hFFFFFFFF, DIVR 123, latency still 33 cycles; `dest`=0 run -> `write_enable` never rises, `busy` timing unchanged.
- Second `start` pulsed at E10 and at E33 -> both ignored, only one write; a `start` held until E34 -> accepted at E34.
- `rst` asserted asynchronously mid-RUN (E15) -> `busy`, `write_enable`, `addrC`, `data_in_C` are 0 immediately, no write occurs, and a fresh operation after release completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative unsigned multiply/divide execute unit. Operands are
//                taken from the register-file read ports when start is
//                accepted. The unit iterates WIDTH cycles and then issues a
//                single-cycle write-back into the register-file write port.
//  Ports       :
//    clk          in   rising-edge clock
//    rst          in   asynchronous active-high reset
//    start        in   request, sampled only while not busy
//    op           in   00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR
//    dest         in   destination register index
//    operand_a    in   multiplicand / dividend
//    operand_b    in   multiplier / divisor
//    busy         out  high from acceptance through the write-back cycle
//    write_enable out  register-file write strobe (one cycle, never for r0)
//    addrC        out  register-file write address (held between write-backs)
//    data_in_C    out  register-file write data (held between write-backs)
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [4:0]       dest,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             write_enable,
   output logic [4:0]       addrC,
   output logic [WIDTH-1:0] data_in_C
);

   localparam int              CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [1:0] OP_MULLO = 2'b00;
   localparam logic [1:0] OP_MULHI = 2'b01;
   localparam logic [1:0] OP_DIVQ  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Captured request
   logic [1:0]         r_op;
   logic [4:0]         r_dest;
   logic [CNT_W-1:0]   r_cnt;

   // Multiply datapath: upper half accumulates, lower half holds the
   // not-yet-consumed multiplier bits and fills with product bits.
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_prod;

   // Divide datapath: r_quot starts as the dividend and shifts quotient bits
   // in from the bottom as dividend bits leave from the top.
   logic [WIDTH-1:0]   r_divisor;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quot;

   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_prod_nxt;
   logic [WIDTH:0]     w_shift;
   logic               w_fits;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quot_nxt;
   logic [WIDTH-1:0]   w_result;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == LAST_ITER) w_state_nxt = S_WB;
         S_WB:    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);

   // ------------------------------------------------------------------------
   // One iteration of each algorithm
   // ------------------------------------------------------------------------
   always_comb begin
      // Shift-add: conditionally add the multiplicand to the upper half, then
      // shift the whole product right, retiring one multiplier bit.
      w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                 + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
      w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

      // Restoring step on the 33-bit partial remainder. A zero divisor always
      // "fits", which naturally yields an all-ones quotient and leaves the
      // dividend as the remainder.
      w_shift    = {r_rem, r_quot[WIDTH-1]};
      w_fits     = (w_shift >= {1'b0, r_divisor});
      // When the subtraction is taken the difference is below the divisor, and
      // when it is not the shifted value is below the divisor, so either
      // result fits in WIDTH bits.
      w_rem_nxt  = w_fits ? (w_shift[WIDTH-1:0] - r_divisor) : w_shift[WIDTH-1:0];
      w_quot_nxt = {r_quot[WIDTH-2:0], w_fits};

      case (r_op)
         OP_MULLO: w_result = w_prod_nxt[WIDTH-1:0];
         OP_MULHI: w_result = w_prod_nxt[2*WIDTH-1:WIDTH];
         OP_DIVQ:  w_result = w_quot_nxt;
         default:  w_result = w_rem_nxt;
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and registered write-port outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op         <= 2'b00;
         r_dest       <= 5'd0;
         r_cnt        <= '0;
         r_mcand      <= '0;
         r_prod       <= '0;
         r_divisor    <= '0;
         r_rem        <= '0;
         r_quot       <= '0;
         write_enable <= 1'b0;
         addrC        <= 5'd0;
         data_in_C    <= '0;
      end else begin
         write_enable <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op      <= op;
                  r_dest    <= dest;
                  r_cnt     <= '0;
                  r_mcand   <= operand_a;
                  r_prod    <= {{WIDTH{1'b0}}, operand_b};
                  r_divisor <= operand_b;
                  r_rem     <= '0;
                  r_quot    <= operand_a;
               end
            end
            S_RUN: begin
               r_cnt  <= r_cnt + 1'b1;
               r_prod <= w_prod_nxt;
               r_rem  <= w_rem_nxt;
               r_quot <= w_quot_nxt;
               if (r_cnt == LAST_ITER) begin
                  addrC        <= r_dest;
                  data_in_C    <= w_result;
                  // r0 is hard-wired in the register file; skip the strobe.
                  write_enable <= (r_dest != 5'd0);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire
